disk_track_ctrl: RTL and testbench

Track-buffer controller for the Disk II emulation. It keeps the 6656-byte (0x1A00) track RAM that the drive model streams from loaded with the current head track. On a head-track change it writes back the old track if dirty, then loads the new one as thirteen 512-byte blocks over the MiSTer-style host block interface. It sits between the drive model (TRACK, TRACK_WE, TRACK_BUSY, DISK_READY) and port B of the dual-port track RAM.

---
 rtl/disk_track_ctrl_if.sv | 22 ++
 rtl/disk_track_ctrl.sv | 150 +++++++++++++++
 tb/tb_disk_track_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disk_track_ctrl_if.sv
// Host block-transfer bus between the track controller (master) and the
// host/SD side (slave).
interface disk_track_ctrl_if;
    logic [31:0] SD_LBA;
    logic        SD_RD;
    logic        SD_WR;
    logic        SD_ACK;
    logic [8:0]  SD_BUFF_ADDR;
    logic [7:0]  SD_BUFF_DOUT;
    logic [7:0]  SD_BUFF_DIN;
    logic        SD_BUFF_WR;

    modport master (
        output SD_LBA, SD_RD, SD_WR, SD_BUFF_DIN,
        input  SD_ACK, SD_BUFF_ADDR, SD_BUFF_DOUT, SD_BUFF_WR
    );

    modport slave (
        input  SD_LBA, SD_RD, SD_WR, SD_BUFF_DIN,
        output SD_ACK, SD_BUFF_ADDR, SD_BUFF_DOUT, SD_BUFF_WR
    );
endinterface

// File: rtl/disk_track_ctrl.sv
// Track-buffer controller: keeps the 13x512 B track RAM loaded with the head
// track, writing back the old track when dirty before loading the new one.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | buffer valid for drive; apply mounts, watch for track change
// WB_REQ  | request block write of cur_track/blk, wait for SD_ACK
// WB_XFER | host reads buffer block out of RAM, wait for SD_ACK fall
// RD_REQ  | request block read of tgt_track/blk, wait for SD_ACK
// RD_XFER | host writes block into RAM, wait for SD_ACK fall
module disk_track_ctrl (
    input  logic                     CLK_14M,
    input  logic                     RESET_N,
    input  logic [5:0]               TRACK,
    input  logic                     TRACK_WE,
    output logic                     TRACK_BUSY,
    output logic                     DISK_READY,
    input  logic                     IMG_MOUNTED,
    input  logic [31:0]              IMG_SIZE,
    input  logic                     IMG_READONLY,
    disk_track_ctrl_if.master        sd,
    output logic [12:0]              RAM_ADDR,
    output logic [7:0]               RAM_DI,
    input  logic [7:0]               RAM_DO,
    output logic                     RAM_WE
);
    typedef enum logic [2:0] {IDLE, WB_REQ, WB_XFER, RD_REQ, RD_XFER} state_t;

    localparam logic [5:0] NO_TRACK   = 6'h3F;
    localparam logic [5:0] LAST_TRACK = 6'd34;
    localparam logic [3:0] LAST_BLK   = 4'd12;

    state_t      state, state_n;
    logic [5:0]  cur_track, cur_track_n, tgt_track, tgt_track_n;
    logic [3:0]  blk, blk_n;
    logic        dirty, dirty_n, mount_pend, mount_pend_n, ready, ready_n;
    logic        ack_q, ack_fall, busy_q;
    logic        ram_we_q, buff_wr_hit;
    logic [12:0] ram_addr_q;
    logic [7:0]  ram_di_q;
    logic [5:0]  lba_track;

    assign ack_fall    = ack_q & ~sd.SD_ACK;
    assign buff_wr_hit = (state == RD_XFER) && sd.SD_BUFF_WR;

    always_comb begin
        state_n      = state;
        cur_track_n  = cur_track;
        tgt_track_n  = tgt_track;
        blk_n        = blk;
        dirty_n      = dirty;
        mount_pend_n = mount_pend;
        ready_n      = ready;
        if (IMG_MOUNTED && state != IDLE) mount_pend_n = 1'b1;
        case (state)
            IDLE: begin
                // a mount takes the whole cycle; the track compare waits one more
                if (mount_pend || IMG_MOUNTED) begin
                    ready_n      = (IMG_SIZE != 32'd0);
                    cur_track_n  = NO_TRACK;
                    dirty_n      = 1'b0;
                    mount_pend_n = 1'b0;
                end else begin
                    if (TRACK_WE) dirty_n = 1'b1;
                    if (ready && TRACK <= LAST_TRACK && TRACK != cur_track) begin
                        tgt_track_n = TRACK;
                        blk_n       = 4'd0;
                        if ((dirty || TRACK_WE) && !IMG_READONLY && cur_track != NO_TRACK)
                            state_n = WB_REQ;
                        else
                            state_n = RD_REQ;
                    end
                end
            end
            WB_REQ:  if (sd.SD_ACK) state_n = WB_XFER;
            WB_XFER: begin
                if (ack_fall) begin
                    if (blk == LAST_BLK) begin
                        blk_n   = 4'd0;
                        dirty_n = 1'b0;
                        state_n = RD_REQ;
                    end else begin
                        blk_n   = blk + 4'd1;
                        state_n = WB_REQ;
                    end
                end
            end
            RD_REQ:  if (sd.SD_ACK) state_n = RD_XFER;
            RD_XFER: begin
                if (ack_fall) begin
                    if (blk == LAST_BLK) begin
                        cur_track_n = tgt_track;
                        state_n     = IDLE;
                    end else begin
                        blk_n   = blk + 4'd1;
                        state_n = RD_REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cur_track  <= NO_TRACK;
            tgt_track  <= 6'd0;
            blk        <= 4'd0;
            dirty      <= 1'b0;
            mount_pend <= 1'b0;
            ready      <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 13'd0;
            ram_di_q   <= 8'd0;
        end else begin
            state      <= state_n;
            cur_track  <= cur_track_n;
            tgt_track  <= tgt_track_n;
            blk        <= blk_n;
            dirty      <= dirty_n;
            mount_pend <= mount_pend_n;
            ready      <= ready_n;
            ack_q      <= sd.SD_ACK;
            // rises with the transfer decision, falls one edge after IDLE is reached
            busy_q     <= (state != IDLE) || (state_n != IDLE);
            ram_we_q   <= buff_wr_hit;
            if (buff_wr_hit) begin
                ram_addr_q <= {blk, sd.SD_BUFF_ADDR};
                ram_di_q   <= sd.SD_BUFF_DOUT;
            end
        end
    end

    assign lba_track = (state == WB_REQ || state == WB_XFER) ? cur_track : tgt_track;

    assign sd.SD_LBA      = (state == IDLE) ? 32'd0
                          : ({26'd0, lba_track} * 32'd13 + {28'd0, blk});
    assign sd.SD_RD       = (state == RD_REQ);
    assign sd.SD_WR       = (state == WB_REQ);
    assign sd.SD_BUFF_DIN = RAM_DO;

    assign RAM_ADDR   = (state == WB_XFER) ? {blk, sd.SD_BUFF_ADDR} : ram_addr_q;
    assign RAM_DI     = ram_di_q;
    assign RAM_WE     = ram_we_q;
    assign TRACK_BUSY = busy_q;
    assign DISK_READY = ready & ~busy_q;
endmodule

// File: tb/tb_disk_track_ctrl.sv
// Bench for disk_track_ctrl: host block model, dual-port track RAM model and
// a queue of expected block requests.
module tb_disk_track_ctrl;
    logic        CLK_14M;
    logic        RESET_N;
    logic [5:0]  TRACK;
    logic        TRACK_WE;
    logic        TRACK_BUSY;
    logic        DISK_READY;
    logic        IMG_MOUNTED;
    logic [31:0] IMG_SIZE;
    logic        IMG_READONLY;
    logic [12:0] RAM_ADDR;
    logic [7:0]  RAM_DI;
    logic [7:0]  RAM_DO;
    logic        RAM_WE;

    disk_track_ctrl_if sd ();

    disk_track_ctrl dut (
        .CLK_14M      (CLK_14M),
        .RESET_N      (RESET_N),
        .TRACK        (TRACK),
        .TRACK_WE     (TRACK_WE),
        .TRACK_BUSY   (TRACK_BUSY),
        .DISK_READY   (DISK_READY),
        .IMG_MOUNTED  (IMG_MOUNTED),
        .IMG_SIZE     (IMG_SIZE),
        .IMG_READONLY (IMG_READONLY),
        .sd           (sd.master),
        .RAM_ADDR     (RAM_ADDR),
        .RAM_DI       (RAM_DI),
        .RAM_DO       (RAM_DO),
        .RAM_WE       (RAM_WE)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] lba;
    } req_t;

    localparam logic [31:0] DISK_BYTES = 32'd232960;

    req_t        q[$];
    logic [7:0]  ram     [0:6655];
    logic [7:0]  exp_ram [0:6655];
    logic        drv_we;
    logic [12:0] drv_addr;
    logic [7:0]  drv_data;
    int          checks;
    int          errors;

    initial CLK_14M = 1'b0;
    always #5 CLK_14M = ~CLK_14M;

    // dual-port track RAM: port A is the drive, port B the controller
    always @(posedge CLK_14M) begin
        if (RAM_WE) ram[RAM_ADDR] <= RAM_DI;
        if (drv_we) ram[drv_addr] <= drv_data;
        RAM_DO <= ram[RAM_ADDR];
    end

    function automatic logic [7:0] pat(input int lba, input int a);
        int v;
        v = (lba * 29) ^ a ^ (a >> 3);
        return v[7:0];
    endfunction

    function automatic void push_load(input int t);
        req_t r;
        for (int b = 0; b < 13; b++) begin
            r.wr  = 1'b0;
            r.lba = 32'(t * 13 + b);
            q.push_back(r);
        end
    endfunction

    function automatic void push_wb(input int t);
        req_t r;
        for (int b = 0; b < 13; b++) begin
            r.wr  = 1'b1;
            r.lba = 32'(t * 13 + b);
            q.push_back(r);
        end
    endfunction

    function automatic void set_exp(input int t);
        for (int b = 0; b < 13; b++)
            for (int a = 0; a < 512; a++)
                exp_ram[b * 512 + a] = pat(t * 13 + b, a);
    endfunction

    task automatic check_ram(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 6656; i++)
            if (ram[i] !== exp_ram[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s ram_content: %0d bytes differ, required 0", name, bad);
        end
    endtask

    task automatic serve_one();
        req_t        e;
        int          n;
        int          bad;
        int          b;
        logic        wr_act;
        logic [12:0] ea;
        logic [7:0]  ed;
        n = 0;
        while (!(sd.SD_RD || sd.SD_WR) && n < 200) begin
            @(negedge CLK_14M);
            n++;
        end
        checks++;
        if (!(sd.SD_RD || sd.SD_WR)) begin
            errors++;
            $display("FAIL req_timeout: no request after %0d cycles, %0d expected pending", n, q.size());
            q.delete();
            return;
        end
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: wr=%0d lba=%0d, required none", sd.SD_WR, sd.SD_LBA);
            return;
        end
        e      = q.pop_front();
        wr_act = sd.SD_WR;
        if ({wr_act, sd.SD_LBA} !== {e.wr, e.lba}) begin
            errors++;
            $display("FAIL req: wr=%0d lba=%0d, required wr=%0d lba=%0d", wr_act, sd.SD_LBA, e.wr, e.lba);
        end
        b = int'(e.lba) % 13;
        sd.SD_ACK = 1'b1;
        @(negedge CLK_14M);
        checks++;
        if ((sd.SD_RD | sd.SD_WR) !== 1'b0) begin
            errors++;
            $display("FAIL req_drop lba=%0d: rd=%0d wr=%0d, required 0", e.lba, sd.SD_RD, sd.SD_WR);
        end
        bad = 0;
        if (wr_act) begin
            for (int a = 0; a < 512; a++) begin
                sd.SD_BUFF_ADDR = 9'(a);
                @(negedge CLK_14M);
                @(negedge CLK_14M);
                if (sd.SD_BUFF_DIN !== exp_ram[b * 512 + a]) bad++;
            end
        end else begin
            for (int a = 0; a < 512; a++) begin
                ed = pat(int'(e.lba), a);
                ea = 13'(b * 512 + a);
                sd.SD_BUFF_ADDR = 9'(a);
                sd.SD_BUFF_DOUT = ed;
                sd.SD_BUFF_WR   = 1'b1;
                @(negedge CLK_14M);
                if ({RAM_WE, RAM_ADDR, RAM_DI} !== {1'b1, ea, ed}) bad++;
            end
            sd.SD_BUFF_WR = 1'b0;
            @(negedge CLK_14M);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL xfer wr=%0d lba=%0d: %0d bytes wrong, required 0", wr_act, e.lba, bad);
        end
        sd.SD_ACK = 1'b0;
        @(negedge CLK_14M);
    endtask

    task automatic serve_all();
        while (q.size() > 0) serve_one();
    endtask

    task automatic mount(input logic [31:0] size, input logic [5:0] trk);
        IMG_SIZE    = size;
        TRACK       = trk;
        IMG_MOUNTED = 1'b1;
        @(negedge CLK_14M);
        IMG_MOUNTED = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK_14M);
        checks++;
        if ({sd.SD_RD, sd.SD_WR, RAM_WE, TRACK_BUSY, DISK_READY} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: rd/wr/we/busy/ready=%b, required 00000",
                     {sd.SD_RD, sd.SD_WR, RAM_WE, TRACK_BUSY, DISK_READY});
        end
        checks++;
        if ({sd.SD_LBA, RAM_ADDR, RAM_DI} !== 53'd0) begin
            errors++;
            $display("FAIL reset_buses: lba=%0d addr=%0d di=%0d, required 0", sd.SD_LBA, RAM_ADDR, RAM_DI);
        end
        RESET_N = 1'b1;
        repeat (10) @(negedge CLK_14M);
        checks++;
        if ({sd.SD_RD, TRACK_BUSY, DISK_READY} !== 3'b0) begin
            errors++;
            $display("FAIL unmounted_idle: rd/busy/ready=%b, required 000", {sd.SD_RD, TRACK_BUSY, DISK_READY});
        end
    endtask

    task automatic test_mount_load();
        mount(DISK_BYTES, 6'd0);
        checks++;
        if ({DISK_READY, TRACK_BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL mount_ready: ready/busy=%b, required 10", {DISK_READY, TRACK_BUSY});
        end
        @(negedge CLK_14M);
        checks++;
        if ({TRACK_BUSY, sd.SD_RD, DISK_READY} !== 3'b110) begin
            errors++;
            $display("FAIL load_start: busy/rd/ready=%b, required 110", {TRACK_BUSY, sd.SD_RD, DISK_READY});
        end
        push_load(0);
        serve_all();
        checks++;
        if ({TRACK_BUSY, DISK_READY} !== 2'b10) begin
            errors++;
            $display("FAIL busy_hold: busy/ready=%b, required 10", {TRACK_BUSY, DISK_READY});
        end
        @(negedge CLK_14M);
        checks++;
        if ({TRACK_BUSY, DISK_READY} !== 2'b01) begin
            errors++;
            $display("FAIL load_done: busy/ready=%b, required 01", {TRACK_BUSY, DISK_READY});
        end
        set_exp(0);
        check_ram("load_t0");
    endtask

    task automatic test_writeback();
        // drive write lands in the same cycle as the track change
        TRACK    = 6'd1;
        TRACK_WE = 1'b1;
        drv_we   = 1'b1;
        drv_addr = 13'd100;
        drv_data = 8'h5A;
        exp_ram[100] = 8'h5A;
        push_wb(0);
        push_load(1);
        @(negedge CLK_14M);
        TRACK_WE = 1'b0;
        drv_we   = 1'b0;
        serve_all();
        set_exp(1);
        repeat (2) @(negedge CLK_14M);
        check_ram("load_t1");
    endtask

    task automatic test_readonly();
        IMG_READONLY = 1'b1;
        TRACK_WE = 1'b1;
        drv_we   = 1'b1;
        drv_addr = 13'd7;
        drv_data = 8'hC3;
        @(negedge CLK_14M);
        TRACK_WE = 1'b0;
        drv_we   = 1'b0;
        @(negedge CLK_14M);
        TRACK = 6'd2;
        push_load(2);
        serve_all();
        set_exp(2);
        repeat (2) @(negedge CLK_14M);
        check_ram("load_t2_ro");
    endtask

    task automatic test_ignore_high_track();
        TRACK = 6'd35;
        repeat (20) @(negedge CLK_14M);
        checks++;
        if ({sd.SD_RD, sd.SD_WR, TRACK_BUSY} !== 3'b0) begin
            errors++;
            $display("FAIL track35: rd/wr/busy=%b, required 000", {sd.SD_RD, sd.SD_WR, TRACK_BUSY});
        end
        TRACK = 6'd2;
    endtask

    task automatic test_track_change_mid_load();
        IMG_READONLY = 1'b0;
        mount(DISK_BYTES, 6'd3);
        push_load(3);
        push_load(5);
        repeat (3) serve_one();
        TRACK = 6'd5;
        serve_all();
        set_exp(5);
        repeat (2) @(negedge CLK_14M);
        check_ram("load_t5");
        checks++;
        if (DISK_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_t5: ready=%b, required 1", DISK_READY);
        end
    endtask

    task automatic test_eject_mid_load();
        TRACK = 6'd6;
        push_load(6);
        repeat (4) serve_one();
        IMG_SIZE    = 32'd0;
        IMG_MOUNTED = 1'b1;
        @(negedge CLK_14M);
        IMG_MOUNTED = 1'b0;
        serve_all();
        set_exp(6);
        repeat (3) @(negedge CLK_14M);
        check_ram("load_t6");
        checks++;
        if ({DISK_READY, TRACK_BUSY} !== 2'b00) begin
            errors++;
            $display("FAIL ejected: ready/busy=%b, required 00", {DISK_READY, TRACK_BUSY});
        end
        TRACK = 6'd7;
        repeat (40) @(negedge CLK_14M);
        checks++;
        if ({sd.SD_RD, sd.SD_WR, TRACK_BUSY} !== 3'b0) begin
            errors++;
            $display("FAIL ejected_idle: rd/wr/busy=%b, required 000", {sd.SD_RD, sd.SD_WR, TRACK_BUSY});
        end
    endtask

    task automatic test_reset_mid_load();
        req_t e;
        int   n;
        mount(DISK_BYTES, 6'd0);
        push_load(0);
        repeat (2) serve_one();
        n = 0;
        while (!sd.SD_RD && n < 200) begin
            @(negedge CLK_14M);
            n++;
        end
        e = q.pop_front();
        checks++;
        if ({sd.SD_RD, sd.SD_LBA} !== {1'b1, e.lba}) begin
            errors++;
            $display("FAIL rst_req: rd=%0d lba=%0d, required rd=1 lba=%0d", sd.SD_RD, sd.SD_LBA, e.lba);
        end
        sd.SD_ACK = 1'b1;
        @(negedge CLK_14M);
        for (int a = 0; a < 10; a++) begin
            sd.SD_BUFF_ADDR = 9'(a);
            sd.SD_BUFF_DOUT = 8'hA5;
            sd.SD_BUFF_WR   = 1'b1;
            @(negedge CLK_14M);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({sd.SD_RD, sd.SD_WR, RAM_WE, TRACK_BUSY, DISK_READY} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_flags: rd/wr/we/busy/ready=%b, required 00000",
                     {sd.SD_RD, sd.SD_WR, RAM_WE, TRACK_BUSY, DISK_READY});
        end
        checks++;
        if ({sd.SD_LBA, RAM_ADDR, RAM_DI} !== 53'd0) begin
            errors++;
            $display("FAIL async_reset_buses: lba=%0d addr=%0d di=%0d, required 0", sd.SD_LBA, RAM_ADDR, RAM_DI);
        end
        sd.SD_ACK     = 1'b0;
        sd.SD_BUFF_WR = 1'b0;
        q.delete();
        @(negedge CLK_14M);
        RESET_N = 1'b1;
        @(negedge CLK_14M);
        mount(DISK_BYTES, 6'd0);
        push_load(0);
        serve_all();
        set_exp(0);
        repeat (2) @(negedge CLK_14M);
        check_ram("reload_t0");
        checks++;
        if ({DISK_READY, TRACK_BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL reload_ready: ready/busy=%b, required 10", {DISK_READY, TRACK_BUSY});
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        RESET_N         = 1'b0;
        TRACK           = 6'd0;
        TRACK_WE        = 1'b0;
        IMG_MOUNTED     = 1'b0;
        IMG_SIZE        = 32'd0;
        IMG_READONLY    = 1'b0;
        drv_we          = 1'b0;
        drv_addr        = 13'd0;
        drv_data        = 8'd0;
        sd.SD_ACK       = 1'b0;
        sd.SD_BUFF_ADDR = 9'd0;
        sd.SD_BUFF_DOUT = 8'd0;
        sd.SD_BUFF_WR   = 1'b0;
        @(negedge CLK_14M);
        test_reset();
        test_mount_load();
        test_writeback();
        test_readonly();
        test_ignore_high_track();
        test_track_change_mid_load();
        test_eject_mid_load();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
